// File: rtl/alu_seq_n.sv
// alu_seq_n: WIDTH-bit handshaked ALU with a registered result/flags stage.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 30).
module alu_seq_n #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [5:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [5:0]       flags
);

  localparam logic [5:0] OP_ADD     = 6'd0;
  localparam logic [5:0] OP_ADDINC  = 6'd2;
  localparam logic [5:0] OP_INCA    = 6'd3;
  localparam logic [5:0] OP_SUB     = 6'd4;
  localparam logic [5:0] OP_SUBDEC  = 6'd5;
  localparam logic [5:0] OP_DECA    = 6'd6;
  localparam logic [5:0] OP_PASSB   = 6'd9;
  localparam logic [5:0] OP_ASL     = 6'd13;
  localparam logic [5:0] OP_ASR     = 6'd14;
  localparam logic [5:0] OP_ZEROS   = 6'd15;
  localparam logic [5:0] OP_ONES    = 6'd16;
  localparam logic [5:0] OP_PASSA   = 6'd17;
  localparam logic [5:0] OP_NOTA    = 6'd18;
  localparam logic [5:0] OP_AND     = 6'd19;
  localparam logic [5:0] OP_ANDNOTA = 6'd20;
  localparam logic [5:0] OP_NAND    = 6'd21;
  localparam logic [5:0] OP_OR      = 6'd22;
  localparam logic [5:0] OP_ORNOTA  = 6'd23;
  localparam logic [5:0] OP_NOR     = 6'd24;
  localparam logic [5:0] OP_XOR     = 6'd25;
  localparam logic [5:0] OP_XORNOTA = 6'd26;
  localparam logic [5:0] OP_XNOR    = 6'd27;
  localparam logic [5:0] OP_LSL     = 6'd28;
  localparam logic [5:0] OP_LSR     = 6'd29;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [5:0] OP_MUL     = 6'd30;
`endif

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state, state_nxt;

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high; a producer holds valid and its payload until that transfer happens.
  logic out_free;
  logic load_single;
  assign out_free = !out_valid || out_ready;

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic [5:0]       single_flags;

  // Every add/sub/inc/dec form goes through one adder: A + add_b + add_cin.
  assign sum = {1'b0, operand_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always_comb begin
    add_b   = operand_b;
    add_cin = 1'b0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (operation)
      OP_ADD, OP_ADDINC, OP_INCA, OP_SUB, OP_SUBDEC, OP_DECA: begin
        case (operation)
          OP_ADDINC: add_cin = 1'b1;
          OP_INCA:   begin add_b = '0;          add_cin = 1'b1; end
          OP_SUB:    begin add_b = ~operand_b;  add_cin = 1'b1; end
          OP_SUBDEC: add_b = ~operand_b;
          OP_DECA:   add_b = '1;
          default:   ;
        endcase
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (operand_a[WIDTH-1] == add_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_PASSB:   alu_res = operand_b;
      OP_ASL: begin
        alu_res = {operand_a[WIDTH-2:0], 1'b0};
        alu_c   = operand_a[WIDTH-1];
        alu_v   = operand_a[WIDTH-1] ^ operand_a[WIDTH-2];
      end
      OP_ASR: begin
        alu_res = {operand_a[WIDTH-1], operand_a[WIDTH-1:1]};
        alu_c   = operand_a[0];
      end
      OP_ZEROS:   alu_res = '0;
      OP_ONES:    alu_res = '1;
      OP_PASSA:   alu_res = operand_a;
      OP_NOTA:    alu_res = ~operand_a;
      OP_AND:     alu_res = operand_a & operand_b;
      OP_ANDNOTA: alu_res = ~operand_a & operand_b;
      OP_NAND:    alu_res = ~(operand_a & operand_b);
      OP_OR:      alu_res = operand_a | operand_b;
      OP_ORNOTA:  alu_res = ~operand_a | operand_b;
      OP_NOR:     alu_res = ~(operand_a | operand_b);
      OP_XOR:     alu_res = operand_a ^ operand_b;
      OP_XORNOTA: alu_res = ~operand_a ^ operand_b;
      OP_XNOR:    alu_res = ~(operand_a ^ operand_b);
      OP_LSL: begin
        alu_res = {operand_a[WIDTH-2:0], 1'b0};
        alu_c   = operand_a[WIDTH-1];
      end
      OP_LSR: begin
        alu_res = {1'b0, operand_a[WIDTH-1:1]};
        alu_c   = operand_a[0];
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:     ;
`endif
      default:    alu_ill = 1'b1;
    endcase
  end

  assign single_flags = alu_ill ? 6'b100001
                                : {2'b00, alu_v, alu_c, alu_res[WIDTH-1], ~|alu_res};

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mul_a, mul_b, acc, acc_step;
  logic [CW-1:0]    cnt;
  logic             mul_done;

  assign acc_step = acc + (mul_b[0] ? mul_a : '0);
`endif

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    load_single = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mul_done    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        in_ready = out_free;
`ifdef ALU_SEQ_MUL_EN
        if (in_valid && out_free) begin
          if (operation == OP_MUL) state_nxt = S_MUL;
          else                     load_single = 1'b1;
        end
`else
        load_single = in_valid && out_free;
`endif
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        // The last partial product is folded in on the loading edge, so the
        // counter parks at its final value until the output register frees.
        if (cnt == CNT_LAST && out_free) begin
          mul_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == S_IDLE) begin
      if (state_nxt == S_MUL) begin
        mul_a <= operand_a;
        mul_b <= operand_b;
        acc   <= '0;
        cnt   <= '0;
      end
    end else if (cnt != CNT_LAST) begin
      acc   <= acc_step;
      mul_a <= {mul_a[WIDTH-2:0], 1'b0};
      mul_b <= {1'b0, mul_b[WIDTH-1:1]};
      cnt   <= cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (load_single) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      flags     <= single_flags;
`ifdef ALU_SEQ_MUL_EN
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= acc_step;
      flags     <= {4'b0100, acc_step[WIDTH-1], ~|acc_step};
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// Bench for alu_seq_n: directed vector table, backpressure and reset sequences,
// and randomized beats scored against an arithmetic reference model.
module tb_alu_seq_n;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic [5:0]   operation = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [5:0]   flags;

  alu_seq_n #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W+5:0] exp_q[$];
  logic [W+5:0] sb_e;
  bit rand_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: flags derived from exact integer arithmetic.
  function automatic logic [W+5:0] model(input logic [5:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint unsigned ua, ub, y, u;
    longint sa, sb, sy, s, smax, smin;
    logic [W-1:0] r;
    logic c, v, busy;
    int k;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    r = '0; c = 1'b0; v = 1'b0; busy = 1'b0;
    case (op)
      6'd0, 6'd2, 6'd3: begin
        y  = (op == 6'd3) ? 0 : ub;
        sy = (op == 6'd3) ? 0 : sb;
        k  = (op == 6'd0) ? 0 : 1;
        u = ua + y + longint'(k);
        r = u[W-1:0];
        c = u >= (longint'(1) <<< W);
        s = sa + sy + longint'(k);
        v = (s > smax) || (s < smin);
      end
      6'd4, 6'd5, 6'd6: begin
        y  = (op == 6'd6) ? 1 : ub;
        sy = (op == 6'd6) ? 1 : sb;
        k  = (op == 6'd5) ? 1 : 0;
        u = ua - y - longint'(k);
        r = u[W-1:0];
        c = ua >= y + longint'(k);
        s = sa - sy - longint'(k);
        v = (s > smax) || (s < smin);
      end
      6'd9:  r = b;
      6'd13: begin r = a << 1; c = a[W-1]; v = a[W-1] != a[W-2]; end
      6'd14: begin r = $signed(a) >>> 1; c = a[0]; end
      6'd15: r = '0;
      6'd16: r = '1;
      6'd17: r = a;
      6'd18: r = ~a;
      6'd19: r = a & b;
      6'd20: r = ~a & b;
      6'd21: r = ~(a & b);
      6'd22: r = a | b;
      6'd23: r = ~a | b;
      6'd24: r = ~(a | b);
      6'd25: r = a ^ b;
      6'd26: r = ~a ^ b;
      6'd27: r = ~(a ^ b);
      6'd28: begin r = a << 1; c = a[W-1]; end
      6'd29: begin r = a >> 1; c = a[0]; end
`ifdef ALU_SEQ_MUL_EN
      6'd30: begin u = ua * ub; r = u[W-1:0]; busy = 1'b1; end
`endif
      default: return {6'b100001, {W{1'b0}}};
    endcase
    return {1'b0, busy, v, c, r[W-1], (r == '0), r};
  endfunction

  // scoreboard: consumes pop in order, accepts push the model's prediction
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_result", result, sb_e[W-1:0]);
          check("sb_flags", flags, sb_e[W+5:W]);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(operation, operand_a, operand_b));
    end
  end

  // driver tasks (called at posedge+1)
  task automatic send(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_valid = 1'b1; operation = op; operand_a = a; operand_b = b;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      n++;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_flags"}, flags, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [5:0]   f;
  } vec_t;
  vec_t tv[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv.push_back('{6'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 6'b001010});
    tv.push_back('{6'd4,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 6'b001100});
    tv.push_back('{6'd0,  32'h00000004, 32'hFFFFFFFC, 32'h00000000, 6'b000101});
    tv.push_back('{6'd13, 32'h80000002, 32'h00000000, 32'h00000004, 6'b001100});
    tv.push_back('{6'd14, 32'hFFFFFFFC, 32'h00000000, 32'hFFFFFFFE, 6'b000010});
    tv.push_back('{6'd29, 32'h7FFFFF3F, 32'h00000000, 32'h3FFFFF9F, 6'b000100});
    tv.push_back('{6'd21, 32'h7FFFFFFF, 32'h00000004, 32'hFFFFFFFB, 6'b000010});
    tv.push_back('{6'd7,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 6'b100001});
    tv.push_back('{6'd3,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 6'b000101});
    tv.push_back('{6'd6,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 6'b000010});
    tv.push_back('{6'd5,  32'h00000005, 32'h00000005, 32'hFFFFFFFF, 6'b000010});
    tv.push_back('{6'd2,  32'h00000001, 32'h00000002, 32'h00000004, 6'b000000});
    tv.push_back('{6'd26, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF00FF00F, 6'b000010});
    tv.push_back('{6'd40, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 6'b100001});
`ifndef ALU_SEQ_MUL_EN
    tv.push_back('{6'd30, 32'h0000000D, 32'h0000000B, 32'h00000000, 6'b100001});
`endif

    out_ready = 1'b1;
    @(posedge clk); #1;
    reset_check("reset_initial");

    // directed table: each beat must show its result one edge after accept
    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].op, tv[i].a, tv[i].b);
      check($sformatf("tv%0d_valid", i), out_valid, 1);
      check($sformatf("tv%0d_result", i), result, tv[i].r);
      check($sformatf("tv%0d_flags", i), flags, tv[i].f);
    end
    wait_drain();

    // backpressure: three ADDs against a stalled consumer
    out_ready = 1'b0;
    send(6'd0, 32'd1, 32'd2);
    fork
      begin
        send(6'd0, 32'd10, 32'd20);
        send(6'd0, 32'd100, 32'd200);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_hold_valid", out_valid, 1);
          check("bp_hold_result", result, 3);
          check("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk); check("bp_stream0", {out_valid, result}, {1'b1, 32'd3});
        @(negedge clk); check("bp_stream1", {out_valid, result}, {1'b1, 32'd30});
        @(negedge clk); check("bp_stream2", {out_valid, result}, {1'b1, 32'd300});
      end
    join
    wait_drain();

    // reset while a result is held, then a 1-cycle op right after release
    out_ready = 1'b0;
    send(6'd0, 32'd5, 32'd6);
    reset_check("reset_midstream");
    out_ready = 1'b1;
    send(6'd25, 32'hA5A5A5A5, 32'h0000FFFF);
    check("post_reset_valid", out_valid, 1);
    check("post_reset_result", result, 32'hA5A55A5A);
    wait_drain();

`ifdef ALU_SEQ_MUL_EN
    // MUL: busy for WIDTH cycles, result appears after WIDTH edges
    send(6'd30, 32'd13, 32'd11);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("mul_in_ready_low", in_ready, 0);
      check("mul_no_early_valid", out_valid, 0);
    end
    @(negedge clk);
    check("mul_valid", out_valid, 1);
    check("mul_result", result, 32'h8F);
    check("mul_flags", flags, 6'b010000);
    @(posedge clk); #1;
    wait_drain();

    // reset four cycles into a multiply discards it
    send(6'd30, 32'd7, 32'd9);
    repeat (4) @(posedge clk);
    #1;
    reset_check("reset_mid_mul");
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      check("mul_aborted_no_output", out_valid, 0);
    end
    @(posedge clk); #1;
    send(6'd0, 32'd40, 32'd2);
    check("post_mul_reset_result", {out_valid, result}, {1'b1, 32'd42});
    wait_drain();
`endif

    // randomized beats with random consumer stalls
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [W-1:0] ra, rb;
          ra = $urandom;
          rb = $urandom;
          case ($urandom_range(0, 3))
            0: ra = 32'h7FFFFFFF;
            1: rb = 32'h80000000;
            default: ;
          endcase
          send(6'($urandom_range(0, 63)), ra, rb);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
